lut_neuron_writer: RTL

//   Runtime-programmable LogicNets neuron: the write side of a neuron truth table.
//   A 2**IN_BITS x OUT_BITS table is streamed in over a valid/ready config port.
//   It is then served as registered lookups with the same M0 -> M1 mapping as a

---
 rtl/lut_neuron_writer_if.sv | 40 ++++
 rtl/lut_neuron_writer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lut_neuron_writer_if.sv
// Config and lookup bundle for lut_neuron_writer.
// The master side (host) drives the table load and lookup requests.
// The slave side (neuron) returns handshake, status and lookup results.
// When LUT_CHECKSUM_EN is defined, the bundle also carries cfg_sum.
interface lut_neuron_writer_if #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2
);
  logic                cfg_start;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [OUT_BITS-1:0] cfg_data;
  logic                load_done;
  logic                in_valid;
  logic [IN_BITS-1:0]  M0;
  logic                out_valid;
  logic [OUT_BITS-1:0] M1;
  logic                lookup_err;
`ifdef LUT_CHECKSUM_EN
  logic [7:0]          cfg_sum;

  modport master (
    output cfg_start, cfg_valid, cfg_data, in_valid, M0,
    input  cfg_ready, load_done, out_valid, M1, lookup_err, cfg_sum
  );
  modport slave (
    input  cfg_start, cfg_valid, cfg_data, in_valid, M0,
    output cfg_ready, load_done, out_valid, M1, lookup_err, cfg_sum
  );
`else
  modport master (
    output cfg_start, cfg_valid, cfg_data, in_valid, M0,
    input  cfg_ready, load_done, out_valid, M1, lookup_err
  );
  modport slave (
    input  cfg_start, cfg_valid, cfg_data, in_valid, M0,
    output cfg_ready, load_done, out_valid, M1, lookup_err
  );
`endif
endinterface

// File: rtl/lut_neuron_writer.sv
// Runtime-loadable LogicNets neuron truth table.
// The 2**IN_BITS x OUT_BITS table is streamed in address order over the
// cfg valid/ready port. It is then served as registered one-cycle lookups
// (M0 -> M1).
// The optional macro LUT_CHECKSUM_EN adds the cfg_sum output, which is the
// mod-256 sum of the accepted beats of the current load.
module lut_neuron_writer #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lut_neuron_writer_if.slave   bus
);
  localparam int DEPTH = 1 << IN_BITS;
  localparam logic [IN_BITS-1:0] LAST_ADDR = {IN_BITS{1'b1}};

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IN_BITS-1:0]  waddr_q, waddr_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0] m1_q, m1_d;
  logic                lookup_err_q, lookup_err_d;
  logic                cfg_ready_s;
  logic                load_done_s;
  logic                wr_en_s;
  logic                rd_en_s;
  logic [OUT_BITS-1:0] rd_data_s;
  logic [OUT_BITS-1:0] table_mem [DEPTH];

  // State register: reset forces a fresh load starting at entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: cfg_start always restarts the load, even over the final beat.
  always_comb begin
    state_d = state_q;
    if (bus.cfg_start) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (bus.cfg_valid && (waddr_q == LAST_ADDR)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // State decode: load handshake while loading, lookups while running.
  always_comb begin
    cfg_ready_s = 1'b0;
    load_done_s = 1'b0;
    wr_en_s     = 1'b0;
    rd_en_s     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        cfg_ready_s = 1'b1;
        wr_en_s     = bus.cfg_valid & ~bus.cfg_start;
      end
      ST_RUN: begin
        load_done_s = 1'b1;
        rd_en_s     = bus.in_valid;
      end
      default: begin
        cfg_ready_s = 1'b0;
        load_done_s = 1'b0;
      end
    endcase
  end

  // Write address, lookup pipeline and the sticky error flag.
  always_comb begin
    waddr_d      = waddr_q;
    out_valid_d  = rd_en_s;
    m1_d         = m1_q;
    lookup_err_d = lookup_err_q;
    if (bus.cfg_start) begin
      waddr_d = {IN_BITS{1'b0}};
    end else if (wr_en_s) begin
      waddr_d = waddr_q + {{(IN_BITS-1){1'b0}}, 1'b1};
    end else begin
      waddr_d = waddr_q;
    end
    if (rd_en_s) begin
      m1_d = rd_data_s;
    end else begin
      m1_d = m1_q;
    end
    if (bus.cfg_start) begin
      lookup_err_d = 1'b0;
    end else if (bus.in_valid && !load_done_s) begin
      lookup_err_d = 1'b1;
    end else begin
      lookup_err_d = lookup_err_q;
    end
  end

  // Datapath registers with defined reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q      <= {IN_BITS{1'b0}};
      out_valid_q  <= 1'b0;
      m1_q         <= {OUT_BITS{1'b0}};
      lookup_err_q <= 1'b0;
    end else begin
      waddr_q      <= waddr_d;
      out_valid_q  <= out_valid_d;
      m1_q         <= m1_d;
      lookup_err_q <= lookup_err_d;
    end
  end

  // Table storage: one synchronous write port, no reset (distributed RAM).
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      table_mem[waddr_q] <= bus.cfg_data;
    end
  end

  assign rd_data_s      = table_mem[bus.M0];
  assign bus.cfg_ready  = cfg_ready_s;
  assign bus.load_done  = load_done_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.M1         = m1_q;
  assign bus.lookup_err = lookup_err_q;

`ifdef LUT_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  // Checksum: cleared by cfg_start, accumulates accepted beats, frozen in RUN.
  always_comb begin
    sum_d = sum_q;
    if (bus.cfg_start) begin
      sum_d = 8'd0;
    end else if (wr_en_s) begin
      sum_d = sum_q + 8'(bus.cfg_data);
    end else begin
      sum_d = sum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= 8'd0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign bus.cfg_sum = sum_q;
`endif
endmodule
